// File: rtl/leaf_hub_endpoint.sv
// Leaf-side hub link terminator: filters inbound hub words by destination ID into a
// small FIFO for the local stage controller, and tags outbound controller payloads.
module leaf_hub_endpoint #(
    parameter int MASTER_FIFO_WIDTH = 15,
    parameter int HUB_FIFO_WIDTH    = 47,
    parameter int LOCAL_ID          = 1,
    parameter int IN_DEPTH          = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [HUB_FIFO_WIDTH-1:0]    upstream_fifo_in_data,
    input  logic                         upstream_fifo_in_valid,
    output logic                         upstream_fifo_in_ready,
    output logic [HUB_FIFO_WIDTH-1:0]    upstream_fifo_out_data,
    output logic                         upstream_fifo_out_valid,
    input  logic                         upstream_fifo_out_ready,
    output logic [MASTER_FIFO_WIDTH-1:0] sc_fifo_out_data,
    output logic                         sc_fifo_out_valid,
    input  logic                         sc_fifo_out_ready,
    input  logic [MASTER_FIFO_WIDTH-1:0] sc_fifo_in_data,
    input  logic                         sc_fifo_in_valid,
    output logic                         sc_fifo_in_ready,
    input  logic                         local_has_message_flying,
    input  logic                         local_has_odd_clusters,
    output logic                         upstream_has_message_flying,
    output logic                         upstream_has_odd_clusters,
    output logic [15:0]                  dropped_count
);

    localparam int HDR_W = HUB_FIFO_WIDTH - MASTER_FIFO_WIDTH;
    localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [HDR_W-1:0] HDR_LOCAL = HDR_W'(LOCAL_ID);
    localparam logic [HDR_W-1:0] HDR_BCAST = '1;
    localparam logic [CNT_W-1:0] IN_FULL_CNT = CNT_W'(IN_DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------- inbound: hub -> filter -> FIFO -> controller ----------------
    logic [MASTER_FIFO_WIDTH-1:0] r_in_mem [IN_DEPTH];
    logic [PTR_W-1:0]             r_in_wptr;
    logic [PTR_W-1:0]             r_in_rptr;
    logic [CNT_W-1:0]             r_in_count;
    logic [15:0]                  r_dropped;

    logic             w_in_full;
    logic             w_in_empty;
    logic [HDR_W-1:0] w_in_hdr;
    logic             w_in_hit;
    logic             w_in_xfer;
    logic             w_in_push;
    logic             w_in_drop;
    logic             w_in_pop;

    assign w_in_full  = (r_in_count == IN_FULL_CNT);
    assign w_in_empty = (r_in_count == '0);
    assign w_in_hdr   = upstream_fifo_in_data[HUB_FIFO_WIDTH-1:MASTER_FIFO_WIDTH];
    assign w_in_hit   = (w_in_hdr == HDR_BCAST) || (w_in_hdr == HDR_LOCAL);
    assign w_in_xfer  = upstream_fifo_in_valid & upstream_fifo_in_ready;
    assign w_in_push  = w_in_xfer & w_in_hit;
    assign w_in_drop  = w_in_xfer & ~w_in_hit;
    assign w_in_pop   = sc_fifo_out_valid & sc_fifo_out_ready;

    // Ready depends only on registered occupancy, so a pop never frees a slot same-cycle.
    assign upstream_fifo_in_ready = ~w_in_full & ~reset;
    assign sc_fifo_out_valid      = ~w_in_empty;
    assign sc_fifo_out_data       = r_in_mem[r_in_rptr];
    assign dropped_count          = r_dropped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_count <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wptr <= r_in_wptr + PTR_W'(1);
            end
            if (w_in_pop) begin
                r_in_rptr <= r_in_rptr + PTR_W'(1);
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_count <= r_in_count + CNT_W'(1);
                2'b01:   r_in_count <= r_in_count - CNT_W'(1);
                default: r_in_count <= r_in_count;
            endcase
            if (w_in_drop) begin
                r_dropped <= sat_inc16(r_dropped);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wptr] <= upstream_fifo_in_data[MASTER_FIFO_WIDTH-1:0];
        end
    end

    // ---------------- outbound: controller -> 2-entry skid -> hub ----------------
    logic [HUB_FIFO_WIDTH-1:0] r_ob_head;
    logic [HUB_FIFO_WIDTH-1:0] r_ob_tail;
    logic [1:0]                r_ob_count;

    logic [HUB_FIFO_WIDTH-1:0] w_ob_word;
    logic                      w_ob_push;
    logic                      w_ob_pop;

    assign w_ob_word = {HDR_LOCAL, sc_fifo_in_data};
    assign w_ob_push = sc_fifo_in_valid & sc_fifo_in_ready;
    assign w_ob_pop  = upstream_fifo_out_valid & upstream_fifo_out_ready;

    assign sc_fifo_in_ready        = (r_ob_count != 2'd2) & ~reset;
    assign upstream_fifo_out_valid = (r_ob_count != 2'd0);
    assign upstream_fifo_out_data  = r_ob_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ob_count <= 2'd0;
        end else begin
            case ({w_ob_push, w_ob_pop})
                2'b10:   r_ob_count <= r_ob_count + 2'd1;
                2'b01:   r_ob_count <= r_ob_count - 2'd1;
                default: r_ob_count <= r_ob_count;
            endcase
        end
    end

    // Head always holds the oldest word; the tail only fills when the head is occupied.
    always_ff @(posedge clk) begin
        if (w_ob_pop) begin
            if (w_ob_push && (r_ob_count == 2'd1)) begin
                r_ob_head <= w_ob_word;
            end else begin
                r_ob_head <= r_ob_tail;
            end
        end else if (w_ob_push) begin
            if (r_ob_count == 2'd0) begin
                r_ob_head <= w_ob_word;
            end else begin
                r_ob_tail <= w_ob_word;
            end
        end
    end

    // ---------------- status toward the root ----------------
    logic r_flying;
    logic r_odd;

    assign upstream_has_message_flying = r_flying;
    assign upstream_has_odd_clusters   = r_odd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flying <= 1'b0;
            r_odd    <= 1'b0;
        end else begin
            r_flying <= local_has_message_flying | ~w_in_empty
                        | (r_ob_count != 2'd0) | upstream_fifo_in_valid;
            r_odd    <= local_has_odd_clusters;
        end
    end

endmodule
